// File: rtl/afifo_pkg.sv
// Shared types, default parameters and helpers for the async FIFO write-side arbiter.
// Lock mode is compiled in when AFIFO_ARB_LOCK_EN is defined.
package afifo_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam int unsigned NREQ_DEF     = 4;
   localparam int unsigned DSIZE_DEF    = 8;
   localparam int unsigned MAXBURST_DEF = 16;

   // Increment an index modulo n (n need not be a power of two).
   function automatic int unsigned idx_wrap(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// Round-robin picker: lowest-index request at or above ptr, wrapping to 0.
// Double-width rotate-mask priority encoder.
module rr_pick #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   localparam int unsigned PW = $clog2(2 * N);

   logic [N-1:0]   req_hi;
   logic [2*N-1:0] dbl;
   logic [PW-1:0]  pos;

   // Low half holds requests at/above ptr, high half the full vector for the wrapped search.
   always_comb begin
      req_hi = req & ({N{1'b1}} << ptr);
      dbl    = {req, req_hi};
      any    = |req;
      pos    = '0;
      for (int i = 2 * N - 1; i >= 0; i--) begin
         if (dbl[i]) pos = PW'(i);
      end
      idx = (pos >= PW'(N)) ? IW'(pos - PW'(N)) : IW'(pos);
   end

endmodule

// File: rtl/afifo_wr_arb.sv
// Write-side arbiter for the async FIFO: round-robin share of the single write port,
// throttled by the registered wfull flag. Optional burst lock under AFIFO_ARB_LOCK_EN.
module afifo_wr_arb
   import afifo_pkg::*;
#(
   parameter  int unsigned NREQ     = NREQ_DEF,
   parameter  int unsigned DSIZE    = DSIZE_DEF,
   parameter  int unsigned MAXBURST = MAXBURST_DEF,
   localparam int unsigned IDW      = $clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*DSIZE-1:0] req_data,
   input  logic [NREQ-1:0]       req_last,
   output logic [NREQ-1:0]       req_ready,
   input  logic                  wfull,
   output logic                  wpush,
   output logic [DSIZE-1:0]      wdata,
   output logic                  gnt_valid,
   output logic [IDW-1:0]        gnt_id
);

   logic [NREQ-1:0] req_qual;
   logic [IDW-1:0]  rr_ptr;
   logic [IDW-1:0]  rr_nxt;
   logic [IDW-1:0]  pick_id;
   logic [IDW-1:0]  sel_id;
   logic            pick_any;
   logic            sel_valid;
   logic            push;

   // Requests are not qualified while reset is held, so every output reads zero.
   assign req_qual = req_valid & {NREQ{wrst_n}};

   rr_pick #(
      .N (NREQ)
   ) u_pick (
      .req (req_qual),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_id)
   );

   assign rr_nxt = IDW'(idx_wrap(32'(sel_id), NREQ));

`ifdef AFIFO_ARB_LOCK_EN
   arb_state_t     state;
   logic [IDW-1:0] owner;
   logic [7:0]     beat_cnt;
   logic [8:0]     beat_nxt;

   assign beat_nxt = {1'b0, beat_cnt} + 9'd1;

   // While locked the owner keeps the grant, even through bubbles.
   always_comb begin
      sel_valid = (state == LOCKED) | pick_any;
      sel_id    = (state == LOCKED) ? owner : pick_id;
   end

   // Pointer and burst FSM; only a push advances anything.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         rr_ptr   <= '0;
         state    <= IDLE;
         owner    <= '0;
         beat_cnt <= '0;
      end else if (push) begin
         rr_ptr <= rr_nxt;
         if (state == IDLE) begin
            if (!req_last[sel_id] && (MAXBURST > 1)) begin
               state    <= LOCKED;
               owner    <= sel_id;
               beat_cnt <= 8'd1;
            end
         end else if (req_last[sel_id] || (beat_nxt == 9'(MAXBURST))) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end else begin
            beat_cnt <= beat_nxt[7:0];
         end
      end
   end
`else
   logic unused_lock_cfg;

   // Per-beat round-robin: burst markers and the beat limit play no part.
   assign unused_lock_cfg = ^{req_last, 8'(MAXBURST)};

   // Selection is the picker result directly.
   always_comb begin
      sel_valid = pick_any;
      sel_id    = pick_id;
   end

   // Round-robin pointer moves past the winner on each push.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         rr_ptr <= '0;
      end else if (push) begin
         rr_ptr <= rr_nxt;
      end
   end
`endif

   // Write-port drive: one-hot ready, push strobe and muxed data of the selected requester.
   always_comb begin
      push      = sel_valid & req_qual[sel_id] & ~wfull;
      wpush     = push;
      gnt_valid = sel_valid;
      gnt_id    = sel_valid ? sel_id : '0;
      req_ready = '0;
      wdata     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (sel_valid && (sel_id == IDW'(i))) begin
            req_ready[i] = ~wfull;
            wdata        = req_data[i*DSIZE +: DSIZE];
         end
      end
   end

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Self-checking bench for afifo_wr_arb: directed scenarios plus random traffic,
// all compared against a behavioural round-robin / burst-lock model.
module tb_afifo_wr_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;
   localparam int unsigned MB = 4;
`ifdef AFIFO_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic            wclk;
   logic            wrst_n;
   logic [N-1:0]    v;
   logic [N-1:0]    l;
   logic [DW-1:0]   d [N];
   logic            wf;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            wpush;
   logic [DW-1:0]   wdata;
   logic            gnt_valid;
   logic [1:0]      gnt_id;

   assign req_data = {d[3], d[2], d[1], d[0]};

   afifo_wr_arb #(
      .NREQ     (N),
      .DSIZE    (DW),
      .MAXBURST (MB)
   ) dut (
      .wclk      (wclk),
      .wrst_n    (wrst_n),
      .req_valid (v),
      .req_data  (req_data),
      .req_last  (l),
      .req_ready (req_ready),
      .wfull     (wf),
      .wpush     (wpush),
      .wdata     (wdata),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state.
   int m_ptr    = 0;
   bit m_locked = 0;
   int m_owner  = 0;
   int m_beats  = 0;

   // Observations from the latest checked cycle.
   int           o_gid;
   int           o_push;
   logic [N-1:0] o_xfer;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr    = 0;
      m_locked = 0;
      m_owner  = 0;
      m_beats  = 0;
   endtask

   // Predict this cycle's outputs, compare, then advance the model as the clock edge will.
   task automatic check_cycle();
      bit           sel_v;
      int           sel;
      bit           e_push;
      logic [N-1:0] e_ready;
      logic [DW-1:0] e_data;
      sel_v = 0;
      sel   = 0;
      if (LOCK_EN && m_locked) begin
         sel_v = 1;
         sel   = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (v[j] && !sel_v) begin
               sel_v = 1;
               sel   = j;
            end
         end
      end
      e_push  = sel_v && v[sel] && !wf;
      e_ready = (sel_v && !wf) ? (N'(1) << sel) : '0;
      e_data  = sel_v ? d[sel] : '0;

      chk("gnt_valid", 32'(gnt_valid), 32'(sel_v));
      chk("gnt_id",    32'(gnt_id),    sel_v ? 32'(sel) : 32'd0);
      chk("wpush",     32'(wpush),     32'(e_push));
      chk("req_ready", 32'(req_ready), 32'(e_ready));
      chk("wdata",     32'(wdata),     32'(e_data));

      o_gid  = int'(gnt_id);
      o_push = int'(wpush);
      o_xfer = e_push ? (N'(1) << sel) : '0;

      if (e_push) begin
         if (LOCK_EN) begin
            if (!m_locked) begin
               if (!l[sel] && MB > 1) begin
                  m_locked = 1;
                  m_owner  = sel;
                  m_beats  = 1;
               end
            end else begin
               m_beats++;
               if (l[sel] || m_beats == MB) begin
                  m_locked = 0;
                  m_beats  = 0;
               end
            end
         end
         m_ptr = (sel + 1) % N;
      end
   endtask

   task automatic cycle();
      @(negedge wclk);
      check_cycle();
      @(posedge wclk);
      #1;
   endtask

   // Assert reset with traffic present, verify quiet outputs, release cleanly.
   task automatic do_reset(input string tag);
      wrst_n = 1'b0;
      #1;
      chk({tag, "_gnt_valid"}, 32'(gnt_valid), 32'd0);
      chk({tag, "_gnt_id"},    32'(gnt_id),    32'd0);
      chk({tag, "_wpush"},     32'(wpush),     32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_wdata"},     32'(wdata),     32'd0);
      model_reset();
      v = '0;
      @(negedge wclk);
      wrst_n = 1'b1;
      @(posedge wclk);
      #1;
   endtask

   // Random traffic; requesters hold valid/data until their beat is accepted.
   task automatic rand_traffic(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         cycle();
         for (int i = 0; i < N; i++) begin
            if (o_xfer[i] || !v[i]) begin
               v[i] = 1'($urandom_range(0, 1));
               d[i] = DW'($urandom);
               l[i] = ($urandom_range(0, 2) == 0);
            end
         end
         wf = ($urandom_range(0, 3) == 0);
      end
   endtask

   initial begin
      int pushes;
      int sparse_exp [3];
      sparse_exp = '{3, 1, 3};

      wrst_n = 1'b0;
      wf     = 1'b0;
      v      = '1;
      l      = '0;
      for (int i = 0; i < N; i++) d[i] = DW'($urandom);
      do_reset("rst_init");

      rand_traffic(20);

      // Reset in the middle of traffic, then fairness with everyone valid.
      v  = '1;
      wf = 1'b0;
      do_reset("rst_mid");
      v      = '1;
      l      = '1;
      pushes = 0;
      for (int i = 0; i < 8; i++) begin
         d[i % N] = DW'($urandom);
         cycle();
         chk("fair_gid", 32'(o_gid), 32'(i % N));
         pushes += o_push;
      end
      chk("fair_pushes", 32'(pushes), 32'd8);

      // Sparse requesters 1 and 3 with the pointer parked at 2.
      v = 4'b0010;
      cycle();
      chk("sparse_setup_gid", 32'(o_gid), 32'd1);
      v = 4'b1010;
      for (int i = 0; i < 3; i++) begin
         d[1] = DW'($urandom);
         d[3] = DW'($urandom);
         cycle();
         chk("sparse_gid", 32'(o_gid), 32'(sparse_exp[i]));
      end

      // Full stall: nothing moves until wfull drops.
      v  = 4'b0100;
      wf = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("stall_push", 32'(o_push), 32'd0);
      end
      wf = 1'b0;
      cycle();
      chk("unstall_gid", 32'(o_gid), 32'd2);
      chk("unstall_push", 32'(o_push), 32'd1);
      v = '1;
      cycle();
      chk("post_stall_gid", 32'(o_gid), 32'd3);

`ifdef AFIFO_ARB_LOCK_EN
      // Requester 0 three-beat burst with a bubble while requester 1 waits.
      v = 4'b0011;
      l = 4'b0000;
      cycle();
      chk("lk_b1_gid", 32'(o_gid), 32'd0);
      v = 4'b0010;
      cycle();
      chk("lk_bubble_gid", 32'(o_gid), 32'd0);
      chk("lk_bubble_push", 32'(o_push), 32'd0);
      v = 4'b0011;
      cycle();
      chk("lk_b2_gid", 32'(o_gid), 32'd0);
      l = 4'b0001;
      cycle();
      chk("lk_b3_gid", 32'(o_gid), 32'd0);
      v = 4'b0010;
      l = 4'b0010;
      cycle();
      chk("lk_after_gid", 32'(o_gid), 32'd1);

      // Requester 2 runs a long burst without last: forced release after MB beats.
      v = 4'b1100;
      l = 4'b0000;
      for (int i = 0; i < MB; i++) begin
         d[2] = DW'($urandom);
         cycle();
         chk("force_gid", 32'(o_gid), 32'd2);
         chk("force_push", 32'(o_push), 32'd1);
      end
      cycle();
      chk("force_release_gid", 32'(o_gid), 32'd3);

      // Reset while locked abandons the burst.
      v = '1;
      do_reset("rst_lock");
      v = '1;
      l = '1;
      cycle();
      chk("post_lock_rst_gid", 32'(o_gid), 32'd0);
`endif

      rand_traffic(400);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Hard bound on simulated time.
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
